// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle RV32I datapath (LW/SW/R/I/BEQ/JAL).
// Moore controls are registered from the next state; only ready/zero-gated strobes are combinational.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_result_src,
    output logic [1:0] o_imm_src,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } moore_t;

    function automatic moore_t moore_of(input state_e s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH:    begin m.mem_req = 1'b1; m.alu_src_b = 2'b10; m.result_src = 2'b10; end
            S_DECODE:   begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b01; end
            S_MEMADR:   begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; end
            S_MEMREAD:  begin m.mem_req = 1'b1; m.adr_src = 1'b1; end
            S_MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; end
            S_MEMWRITE: begin m.mem_req = 1'b1; m.adr_src = 1'b1; m.mem_write = 1'b1; end
            S_EXECR:    begin m.alu_src_a = 2'b10; m.alu_op = 2'b10; end
            S_EXECI:    begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; m.alu_op = 2'b10; end
            S_ALUWB:    begin m.reg_write = 1'b1; end
            S_JAL:      begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b10; end
            S_BEQ:      begin m.alu_src_a = 2'b10; m.alu_op = 2'b01; end
            default:    ;
        endcase
        return m;
    endfunction

    state_e state_q, state_d;
    moore_t moore_q, moore_d;
    logic   mem_rdy;
    logic   op_known;

    assign mem_rdy = (MEM_WAIT_EN == 0) ? 1'b1 : i_mem_ready;

    always_comb begin
        op_known = 1'b0;
        case (i_opcode)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_known = 1'b1;
            default:                                  op_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        moore_d = moore_of(state_d);
    end

    // Controls are precomputed from the next state so they stay aligned with state_q.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_FETCH;
            moore_q <= moore_of(S_FETCH);
        end else begin
            state_q <= state_d;
            moore_q <= moore_d;
        end
    end

    always_comb begin
        o_mem_req    = moore_q.mem_req;
        o_mem_write  = moore_q.mem_write;
        o_adr_src    = moore_q.adr_src;
        o_reg_write  = moore_q.reg_write;
        o_alu_src_a  = moore_q.alu_src_a;
        o_alu_src_b  = moore_q.alu_src_b;
        o_alu_op     = moore_q.alu_op;
        o_result_src = moore_q.result_src;
        o_ir_write   = (state_q == S_FETCH) && mem_rdy;
        o_pc_write   = ((state_q == S_FETCH) && mem_rdy) || (state_q == S_JAL) ||
                       ((state_q == S_BEQ) && i_zero);
        o_illegal    = (state_q == S_DECODE) && !op_known;
        case (i_opcode)
            OP_SW:   o_imm_src = 2'b01;
            OP_BEQ:  o_imm_src = 2'b10;
            OP_JAL:  o_imm_src = 2'b11;
            default: o_imm_src = 2'b00;
        endcase
        if (i_rst) begin
            o_mem_req    = 1'b0;
            o_mem_write  = 1'b0;
            o_adr_src    = 1'b0;
            o_reg_write  = 1'b0;
            o_alu_src_a  = '0;
            o_alu_src_b  = '0;
            o_alu_op     = '0;
            o_result_src = '0;
            o_ir_write   = 1'b0;
            o_pc_write   = 1'b0;
            o_illegal    = 1'b0;
            o_imm_src    = '0;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model checked every cycle,
// a table of per-instruction expectations, and hand-written reset / no-wait sequences.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] ECL = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, zero, rdy;
    logic [6:0] op;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic [3:0] st;

    logic       nw_mem_req, nw_mem_write, nw_adr_src, nw_ir_write, nw_pc_write, nw_reg_write, nw_illegal;
    logic [1:0] nw_alu_src_a, nw_alu_src_b, nw_alu_op, nw_result_src, nw_imm_src;
    logic [3:0] nw_st;

    multicycle_controller dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_zero(zero), .i_mem_ready(rdy),
        .o_mem_req(mem_req), .o_mem_write(mem_write), .o_adr_src(adr_src),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_result_src(result_src), .o_imm_src(imm_src), .o_illegal(illegal), .o_state(st)
    );

    multicycle_controller #(.MEM_WAIT_EN(0)) dut_nw (
        .i_clk(clk), .i_rst(rst), .i_opcode(op), .i_zero(zero), .i_mem_ready(rdy),
        .o_mem_req(nw_mem_req), .o_mem_write(nw_mem_write), .o_adr_src(nw_adr_src),
        .o_ir_write(nw_ir_write), .o_pc_write(nw_pc_write), .o_reg_write(nw_reg_write),
        .o_alu_src_a(nw_alu_src_a), .o_alu_src_b(nw_alu_src_b), .o_alu_op(nw_alu_op),
        .o_result_src(nw_result_src), .o_imm_src(nw_imm_src), .o_illegal(nw_illegal), .o_state(nw_st)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] res;
        logic [1:0] imm;
        logic       illegal;
        logic [3:0] state;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        logic       waits;
    } phase_t;

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         waits;
        int         cyc;
        int         memw;
        int         regw;
        int         pcx;
        int         ill;
        int         imm;
    } vec_t;

    int checks = 0;
    int errors = 0;
    phase_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic known(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, JAL, BEQ};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Per-instruction phase list: state number plus whether it waits on ready.
    function automatic void build(input logic [6:0] o);
        q.delete();
        q.push_back('{4'd0, 1'b1});
        q.push_back('{4'd1, 1'b0});
        case (o)
            LW:  begin q.push_back('{4'd2, 1'b0}); q.push_back('{4'd3, 1'b1}); q.push_back('{4'd4, 1'b0}); end
            SW:  begin q.push_back('{4'd2, 1'b0}); q.push_back('{4'd5, 1'b1}); end
            RT:  begin q.push_back('{4'd6, 1'b0}); q.push_back('{4'd7, 1'b0}); end
            IT:  begin q.push_back('{4'd8, 1'b0}); q.push_back('{4'd7, 1'b0}); end
            JAL: begin q.push_back('{4'd9, 1'b0}); q.push_back('{4'd7, 1'b0}); end
            BEQ: q.push_back('{4'd10, 1'b0});
            default: ;
        endcase
    endfunction

    function automatic out_t exp_of(input logic [3:0] s, input logic r, input logic z, input logic [6:0] o);
        out_t e;
        e = '0;
        e.state = s;
        e.imm = imm_of(o);
        case (s)
            4'd0:  begin e.mem_req = 1; e.b = 2'b10; e.res = 2'b10; e.ir_write = r; e.pc_write = r; end
            4'd1:  begin e.a = 2'b01; e.b = 2'b01; e.illegal = !known(o); end
            4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
            4'd3:  begin e.mem_req = 1; e.adr_src = 1; end
            4'd4:  begin e.res = 2'b01; e.reg_write = 1; end
            4'd5:  begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
            4'd6:  begin e.a = 2'b10; e.aop = 2'b10; end
            4'd7:  e.reg_write = 1;
            4'd8:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            4'd9:  begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
            4'd10: begin e.a = 2'b10; e.aop = 2'b01; e.pc_write = z; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.mem_req = mem_req;   s.mem_write = mem_write; s.adr_src = adr_src;
        s.ir_write = ir_write; s.pc_write = pc_write;   s.reg_write = reg_write;
        s.a = alu_src_a;       s.b = alu_src_b;         s.aop = alu_op;
        s.res = result_src;    s.imm = imm_src;         s.illegal = illegal;
        s.state = st;
        return s;
    endfunction

    // Entered just after a negedge; drives, checks against the model, leaves after the next negedge.
    task automatic step(input logic r, input logic z, output out_t got);
        out_t e;
        rdy = r;
        zero = z;
        #1;
        if (q.size() == 0) build(op);
        e = exp_of(q[0].st, r, z, op);
        got = sample();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL cycle_outputs op=%b model_state=%0d actual=%h required=%h", op, q[0].st, got, e);
        end
        if (!(q[0].waits && !r)) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        out_t g;
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            rdy = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            g = sample();
            g.state = '0;
            chk("rst_outputs_zero", 32'(g), 32'd0);
            if (k > 0) chk("rst_state", 32'(st), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        chk("rst_state_after", 32'(st), 32'd0);
        q.delete();
    endtask

    task automatic run_instr(input logic [6:0] o, input logic z, input int waits, input bit rnd,
                             output int cyc, output int memw, output int regw,
                             output int pcx, output int ill, output int imm_dec);
        out_t g;
        logic r, zz;
        bit done;
        op = o;
        q.delete();
        cyc = -1; memw = 0; regw = 0; pcx = 0; ill = 0; imm_dec = 0;
        done = 0;
        for (int idx = 0; idx < 60 && !done; idx++) begin
            if (idx > 0 && st == 4'd0) begin
                cyc = idx;
                done = 1;
            end else begin
                r  = rnd ? ($urandom_range(0, 9) < 7) : !(idx >= 3 && idx < 3 + waits);
                zz = rnd ? 1'($urandom_range(0, 1)) : z;
                step(r, zz, g);
                if (g.mem_write) memw++;
                if (g.reg_write) regw++;
                if (g.pc_write && g.state != 4'd0) pcx++;
                if (g.illegal) ill++;
                if (idx == 1) imm_dec = int'(g.imm);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_timeout op=%b actual=no_return required=FETCH", o);
        end
    endtask

    initial begin
        vec_t tbl[9];
        logic [6:0] ops[7];
        int seq[6];
        int cyc, memw, regw, pcx, ill, imm;
        out_t g;

        tbl[0] = '{LW,  1'b0, 0, 5, 0, 1, 0, 0, 0};
        tbl[1] = '{LW,  1'b0, 1, 6, 0, 1, 0, 0, 0};
        tbl[2] = '{SW,  1'b0, 2, 6, 3, 0, 0, 0, 1};
        tbl[3] = '{RT,  1'b0, 0, 4, 0, 1, 0, 0, 0};
        tbl[4] = '{IT,  1'b0, 0, 4, 0, 1, 0, 0, 0};
        tbl[5] = '{JAL, 1'b0, 0, 4, 0, 1, 1, 0, 3};
        tbl[6] = '{BEQ, 1'b1, 0, 3, 0, 0, 1, 0, 2};
        tbl[7] = '{BEQ, 1'b0, 0, 3, 0, 0, 0, 0, 2};
        tbl[8] = '{ECL, 1'b0, 0, 2, 0, 0, 0, 1, 0};
        ops = '{LW, SW, RT, IT, JAL, BEQ, ECL};
        seq = '{0, 1, 2, 3, 4, 0};

        rst = 1'b1; op = '0; zero = 1'b0; rdy = 1'b1;
        @(negedge clk);
        do_reset(2);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].z, tbl[i].waits, 1'b0, cyc, memw, regw, pcx, ill, imm);
            chk($sformatf("cycles[%0d]", i),      32'(cyc),  32'(tbl[i].cyc));
            chk($sformatf("mem_write[%0d]", i),   32'(memw), 32'(tbl[i].memw));
            chk($sformatf("reg_write[%0d]", i),   32'(regw), 32'(tbl[i].regw));
            chk($sformatf("pc_write_x[%0d]", i),  32'(pcx),  32'(tbl[i].pcx));
            chk($sformatf("illegal[%0d]", i),     32'(ill),  32'(tbl[i].ill));
            chk($sformatf("imm_src[%0d]", i),     32'(imm),  32'(tbl[i].imm));
        end

        // Reset arriving in MEMREAD abandons the load.
        op = LW;
        q.delete();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, g);
        chk("pre_rst_state", 32'(st), 32'd3);
        do_reset(1);
        run_instr(LW, 1'b0, 0, 1'b0, cyc, memw, regw, pcx, ill, imm);
        chk("lw_after_rst_cycles", 32'(cyc), 32'd5);
        chk("lw_after_rst_regw", 32'(regw), 32'd1);

        // Ready held low: the no-wait instance completes LW in 5 cycles, the default one stalls.
        op = LW;
        rdy = 1'b0;
        zero = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("nw_state[%0d]", c), 32'(nw_st), 32'(seq[c]));
            chk($sformatf("nw_regw[%0d]", c), 32'(nw_reg_write), 32'(c == 4));
            chk($sformatf("stall_state[%0d]", c), 32'(st), 32'd0);
            chk($sformatf("stall_ir_write[%0d]", c), 32'(ir_write), 32'd0);
            @(negedge clk);
        end
        do_reset(1);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            o = ($urandom_range(0, 7) == 7) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            run_instr(o, 1'b0, 0, 1'b1, cyc, memw, regw, pcx, ill, imm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
